edge_counter_bank: RTL
======================

Name: edge_counter_bank

Overview:
Multi-channel, parametrised successor to the single-input edge counter. Each channel synchronises an asynchronous level input, debounces it, and detects edges per a run-time mode. It counts qualifying edges with selectable wrap or saturate behaviour, and reports a per-channel edge pulse and a sticky overflow flag. Sits between raw external event lines and status/telemetry registers.

Parameters:
N_CH, 4, number of independent channels
N_BITS, 4, counter width per channel
DB_CYCLES, 0, extra consecutive cycles a synchronised level change must persist before acceptance (0 = no debounce)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable (all channels)
mode  input  2  edge select: 00 rising, 01 falling, 10 both, 11 none
sat  input  1  1 = saturate at max, 0 = wrap to 0
clr  input  N_CH  per-channel synchronous clear of count and ovf
in  input  N_CH  asynchronous level inputs
out  output  N_CH*N_BITS  counts; channel i at bits [i*N_BITS +: N_BITS]
pulse  output  N_CH  one-cycle flag: qualifying edge accepted this cycle
ovf  output  N_CH  sticky overflow flag

Behaviour:
- Reset (rst=1 at clk edge): out=0, pulse=0, ovf=0, both sync stages=0, filtered level=0, debounce counters=0. rst overrides every other input.
- Per channel: 2-flop synchroniser (s1<=in, s2<=s1), filtered level filt, debounce counter dbc, width clog2(DB_CYCLES+1), minimum 1.
- s2==filt: dbc<=0, no acceptance.
- s2!=filt and dbc<DB_CYCLES: dbc<=dbc+1.
- s2!=filt and dbc==DB_CYCLES: accept. filt<=s2, dbc<=0.
- Net effect: a change at s2 must hold DB_CYCLES+1 consecutive cycles. Shorter glitches are discarded with no pulse and no count.
- Edge type: 0->1 is rising, 1->0 is falling. A qualifying edge is an accepted transition matching mode. mode=11 never qualifies. mode is sampled on the accepting cycle.
- pulse[i] is registered: high for exactly the cycle following the accepting edge. It depends on mode only and is independent of en and clr.
- Latency with DB_CYCLES=0: in changes before edge k. s1 at k, s2 at k+1, accept at k+2. pulse and updated out are visible after edge k+2. General latency is 3+DB_CYCLES edges.
- Count update on a qualifying edge with en=1:
  - count<max: count+1.
  - count==max, sat=0: count<=0, ovf<=1.
  - count==max, sat=1: count holds max, ovf<=1.
- en=0: filt/dbc tracking and pulse continue, but there is no count change.
- clr[i]=1: count<=0 and ovf<=0. This has priority over a simultaneous increment; the edge is lost for counting but pulse is still asserted.
- ovf stays set until clr[i] or rst. Further overflows keep it at 1.
- Channels are fully independent. Simultaneous edges on several channels each count.
- An input held high through reset yields filt 0->1, i.e. a rising edge accepted 3+DB_CYCLES edges after rst deasserts.
- No combinational path from any input to any output.

Test Plan:
- Reset, N_CH=4/N_BITS=4/DB=0, mode=00, en=1. in[0] 0->1 before edge 10 -> pulse[0]=1 only in the cycle after edge 12; out[3:0]=1; other channels 0.
- mode=10, in[1] toggled 5 times, each level held 4 cycles -> 5 single-cycle pulses; out[7:4]=5. Repeat with mode=01 starting low, 4 toggles -> out[7:4]=2.
- sat=0, 17 rising edges on ch2 -> out[11:8]=1 and ovf[2]=1. sat=1, 20 rising edges on ch3 -> out[15:12]=15 and ovf[3]=1. Then pulse clr[3] -> out[15:12]=0, ovf[3]=0.
- DB_CYCLES=3: 3-cycle-wide high glitch on in[0] -> no pulse, count 0. 4-cycle-wide high -> accepted, pulse after edge 3+3 relative to s1 capture; count 1.
- en=0 during 3 rising edges -> pulse asserted 3 times, count unchanged. clr[0] on the same cycle as an accepting edge -> count 0, pulse 1.
- Reset asserted mid-count (out[3:0]=6, ovf set) -> all outputs 0 next cycle. in held high through reset -> one counted rising edge 3 cycles after release.

Source files
------------

// File: rtl/edge_counter_bank_if.sv
// rtl/edge_counter_bank_if.sv - control, event-line and status bundle for edge_counter_bank
interface edge_counter_bank_if #(
    parameter int N_CH   = 4,
    parameter int N_BITS = 4
);
    logic                     en;
    logic [1:0]               mode;
    logic                     sat;
    logic [N_CH-1:0]          clr;
    logic [N_CH-1:0]          in;
    logic [N_CH*N_BITS-1:0]   out;
    logic [N_CH-1:0]          pulse;
    logic [N_CH-1:0]          ovf;

    modport master (
        output en, mode, sat, clr, in,
        input  out, pulse, ovf
    );

    modport slave (
        input  en, mode, sat, clr, in,
        output out, pulse, ovf
    );
endinterface

// File: rtl/edge_counter_bank.sv
// rtl/edge_counter_bank.sv - multi-channel synchronised, debounced edge counter with wrap/saturate
module edge_counter_bank #(
    parameter int N_CH      = 4,
    parameter int N_BITS    = 4,
    parameter int DB_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    edge_counter_bank_if.slave bus
);
    localparam int                DBW     = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DBW-1:0]    DB_LAST = DBW'(DB_CYCLES);
    localparam logic [N_BITS-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]   s1;
    logic [N_CH-1:0]   s2;
    logic [N_CH-1:0]   filt;
    logic [N_CH-1:0]   pulse_r;
    logic [N_CH-1:0]   ovf_r;
    logic [DBW-1:0]    dbc [N_CH];
    logic [N_BITS-1:0] cnt [N_CH];

    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   qual;
    logic              sel_rise;
    logic              sel_fall;

    // A level change is accepted once it has held for DB_CYCLES+1 consecutive samples
    always_comb begin
        accept   = '0;
        qual     = '0;
        sel_rise = (bus.mode == 2'b00) || (bus.mode == 2'b10);
        sel_fall = (bus.mode == 2'b01) || (bus.mode == 2'b10);
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (s2[i] != filt[i]) && (dbc[i] == DB_LAST);
            qual[i]   = accept[i] && ((s2[i] && sel_rise) || (!s2[i] && sel_fall));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            filt    <= '0;
            pulse_r <= '0;
            ovf_r   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dbc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            s1      <= bus.in;
            s2      <= s1;
            pulse_r <= qual;
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == filt[i]) begin
                    dbc[i] <= '0;
                end else if (accept[i]) begin
                    filt[i] <= s2[i];
                    dbc[i]  <= '0;
                end else begin
                    dbc[i] <= dbc[i] + DBW'(1);
                end

                // Clear wins over a coincident increment; the pulse is still reported
                if (bus.clr[i]) begin
                    cnt[i]   <= '0;
                    ovf_r[i] <= 1'b0;
                end else if (bus.en && qual[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf_r[i] <= 1'b1;
                        cnt[i]   <= bus.sat ? CNT_MAX : '0;
                    end else begin
                        cnt[i] <= cnt[i] + N_BITS'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.out = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.out[i*N_BITS +: N_BITS] = cnt[i];
        end
    end

    assign bus.pulse = pulse_r;
    assign bus.ovf   = ovf_r;
endmodule
